// File: rtl/snitch_sb_tag_table.sv
// Scoreboard tag table: allocates pool tags to issuing instructions, tracks their
// destination registers for RAW/WAW checks, and returns tags on writeback or flush.
module snitch_sb_tag_table #(
    parameter int unsigned NumTags      = 8,
    parameter int unsigned RegAddrWidth = 5,
    parameter int unsigned NumQuery     = 3,
    localparam int unsigned TagWidth    = $clog2(NumTags)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   issue_valid_i,
    input  logic [RegAddrWidth-1:0]                issue_rd_i,
    output logic                                   issue_ready_o,
    output logic [TagWidth-1:0]                    issue_tag_o,
    input  logic                                   pool_empty_i,
    input  logic [TagWidth-1:0]                    pool_tag_i,
    output logic                                   pool_pop_o,
    output logic                                   pool_push_o,
    output logic [TagWidth-1:0]                    pool_tag_o,
    input  logic                                   wb_valid_i,
    input  logic [TagWidth-1:0]                    wb_tag_i,
    output logic                                   wb_err_o,
    input  logic [NumQuery-1:0][RegAddrWidth-1:0]  query_rs_i,
    output logic [NumQuery-1:0]                    hazard_o,
    input  logic                                   flush_i,
    output logic                                   busy_o,
    output logic [TagWidth:0]                      inflight_o
);

    localparam logic [0:0] Idle  = 1'b0;
    localparam logic [0:0] Flush = 1'b1;

    logic [0:0]                                state_q;
    logic [TagWidth-1:0]                       idx_q;
    logic [NumTags-1:0]                        valid_q, valid_d;
    logic [NumTags-1:0][RegAddrWidth-1:0]      rd_q;
    logic                                      ret_valid_q;
    logic [TagWidth-1:0]                       ret_tag_q;
    logic                                      wb_err_q;
    logic [TagWidth:0]                         inflight_q, inflight_d;

    logic waw, fire, wb_hit, scan_clr, idx_last;

    always_comb begin
        waw = 1'b0;
        for (int t = 0; t < NumTags; t++) begin
            if (valid_q[t] && rd_q[t] == issue_rd_i) waw = 1'b1;
        end
        waw = waw && (issue_rd_i != '0);
    end

    assign issue_ready_o = (state_q == Idle) && !pool_empty_i && !flush_i && !waw;
    assign fire          = issue_valid_i && issue_ready_o;
    assign pool_pop_o    = fire;
    assign issue_tag_o   = pool_tag_i;

    // Writeback owns the single return slot; the scan only advances when it is free.
    assign wb_hit   = wb_valid_i && valid_q[wb_tag_i];
    assign scan_clr = (state_q == Flush) && !wb_hit && valid_q[idx_q];
    assign idx_last = (idx_q == TagWidth'(NumTags - 1));

    always_comb begin
        valid_d = valid_q;
        if (wb_hit)   valid_d[wb_tag_i]   = 1'b0;
        if (scan_clr) valid_d[idx_q]      = 1'b0;
        if (fire)     valid_d[pool_tag_i] = 1'b1;
    end

    assign inflight_d = inflight_q + (TagWidth+1)'(fire) - (TagWidth+1)'(wb_hit | scan_clr);

    // Hazards look only at registered state, so same-cycle issue/writeback is invisible.
    for (genvar q = 0; q < NumQuery; q++) begin : g_query
        logic match;
        always_comb begin
            match = 1'b0;
            for (int t = 0; t < NumTags; t++) begin
                if (valid_q[t] && rd_q[t] == query_rs_i[q]) match = 1'b1;
            end
        end
        assign hazard_o[q] = match && (query_rs_i[q] != '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= Idle;
            idx_q       <= '0;
            valid_q     <= '0;
            rd_q        <= '0;
            ret_valid_q <= 1'b0;
            ret_tag_q   <= '0;
            wb_err_q    <= 1'b0;
            inflight_q  <= '0;
        end else begin
            valid_q     <= valid_d;
            inflight_q  <= inflight_d;
            wb_err_q    <= wb_valid_i && !valid_q[wb_tag_i];
            ret_valid_q <= wb_hit | scan_clr;
            if (fire) rd_q[pool_tag_i] <= issue_rd_i;
            if (wb_hit)        ret_tag_q <= wb_tag_i;
            else if (scan_clr) ret_tag_q <= idx_q;
            if (state_q == Idle) begin
                if (flush_i) begin
                    state_q <= Flush;
                    idx_q   <= '0;
                end
            end else if (!wb_hit) begin
                if (idx_last) begin
                    state_q <= Idle;
                    idx_q   <= '0;
                end else begin
                    idx_q <= idx_q + TagWidth'(1);
                end
            end
        end
    end

    assign pool_push_o = ret_valid_q;
    assign pool_tag_o  = ret_tag_q;
    assign wb_err_o    = wb_err_q;
    assign busy_o      = (state_q == Flush);
    assign inflight_o  = inflight_q;

endmodule

// File: tb/tb_snitch_sb_tag_table.sv
// Bench for snitch_sb_tag_table: directed scenarios plus random traffic, with the
// ID pool and the expected table contents modelled as plain arrays and a queue.
module tb_snitch_sb_tag_table;
    localparam int NT = 8;
    localparam int RW = 5;
    localparam int NQ = 3;
    localparam int TW = 3;

    logic                   clk_i = 1'b0;
    logic                   rst_i = 1'b0;
    logic                   issue_valid_i;
    logic [RW-1:0]          issue_rd_i;
    logic                   issue_ready_o;
    logic [TW-1:0]          issue_tag_o;
    logic                   pool_empty_i;
    logic [TW-1:0]          pool_tag_i;
    logic                   pool_pop_o;
    logic                   pool_push_o;
    logic [TW-1:0]          pool_tag_o;
    logic                   wb_valid_i;
    logic [TW-1:0]          wb_tag_i;
    logic                   wb_err_o;
    logic [NQ-1:0][RW-1:0]  query_rs_i;
    logic [NQ-1:0]          hazard_o;
    logic                   flush_i;
    logic                   busy_o;
    logic [TW:0]            inflight_o;

    always #5 clk_i = ~clk_i;

    snitch_sb_tag_table #(.NumTags(NT), .RegAddrWidth(RW), .NumQuery(NQ)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
        .issue_ready_o(issue_ready_o), .issue_tag_o(issue_tag_o),
        .pool_empty_i(pool_empty_i), .pool_tag_i(pool_tag_i),
        .pool_pop_o(pool_pop_o), .pool_push_o(pool_push_o), .pool_tag_o(pool_tag_o),
        .wb_valid_i(wb_valid_i), .wb_tag_i(wb_tag_i), .wb_err_o(wb_err_o),
        .query_rs_i(query_rs_i), .hazard_o(hazard_o),
        .flush_i(flush_i), .busy_o(busy_o), .inflight_o(inflight_o)
    );

    // Reference: which tags are in flight and for which register, the pool contents,
    // and the flush walk position.
    bit m_valid[NT];
    int m_rd[NT];
    bit m_flush;
    int m_idx;
    bit m_push;
    int m_ptag;
    bit m_err;
    int pool[$];

    int checks = 0;
    int errors = 0;
    int push_log[$];
    int busy_cycles;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic bit m_reg_busy(input int r);
        if (r == 0) return 1'b0;
        for (int t = 0; t < NT; t++) if (m_valid[t] && m_rd[t] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int t = 0; t < NT; t++) n += int'(m_valid[t]);
        return n;
    endfunction

    task automatic model_reset();
        for (int t = 0; t < NT; t++) begin m_valid[t] = 1'b0; m_rd[t] = 0; end
        m_flush = 1'b0; m_idx = 0; m_push = 1'b0; m_ptag = 0; m_err = 1'b0;
        pool.delete();
        for (int t = 0; t < NT; t++) pool.push_back(t);
    endtask

    task automatic refresh_pool();
        pool_empty_i = (pool.size() == 0);
        pool_tag_i   = (pool.size() != 0) ? TW'(pool[0]) : '0;
    endtask

    task automatic model_step(input bit fire);
        int  wt       = int'(wb_tag_i);
        bit  hit      = wb_valid_i && m_valid[wt];
        bit  old_push = m_push;
        int  old_tag  = m_ptag;
        int  ftag     = fire ? pool[0] : 0;
        m_err  = wb_valid_i && !m_valid[wt];
        m_push = 1'b0;
        if (hit) begin
            m_valid[wt] = 1'b0; m_push = 1'b1; m_ptag = wt;
        end
        if (!m_flush) begin
            if (flush_i) begin m_flush = 1'b1; m_idx = 0; end
        end else if (!hit) begin
            if (m_valid[m_idx]) begin
                m_valid[m_idx] = 1'b0; m_push = 1'b1; m_ptag = m_idx;
            end
            if (m_idx == NT - 1) m_flush = 1'b0;
            else m_idx++;
        end
        if (fire) begin
            void'(pool.pop_front());
            m_valid[ftag] = 1'b1;
            m_rd[ftag]    = int'(issue_rd_i);
        end
        if (old_push) pool.push_back(old_tag);
    endtask

    task automatic tick();
        bit e_ready, e_fire;
        @(negedge clk_i);
        e_ready = !m_flush && pool.size() != 0 && !flush_i && !m_reg_busy(int'(issue_rd_i));
        e_fire  = issue_valid_i && e_ready;
        chk("issue_ready", issue_ready_o, e_ready);
        chk("pool_pop", pool_pop_o, e_fire);
        if (e_fire) chk("issue_tag", issue_tag_o, pool[0]);
        chk("pool_push", pool_push_o, m_push);
        chk("pool_tag", pool_tag_o, m_ptag);
        chk("wb_err", wb_err_o, m_err);
        chk("busy", busy_o, m_flush);
        chk("inflight", inflight_o, m_count());
        for (int q = 0; q < NQ; q++) chk("hazard", hazard_o[q], m_reg_busy(int'(query_rs_i[q])));
        if (pool_push_o) push_log.push_back(int'(pool_tag_o));
        if (busy_o) busy_cycles++;
        @(posedge clk_i);
        model_step(e_fire);
        #1 refresh_pool();
    endtask

    task automatic drive(input bit iv, input int rd, input bit wv, input int wt, input bit fl);
        issue_valid_i = iv;
        issue_rd_i    = RW'(rd);
        wb_valid_i    = wv;
        wb_tag_i      = TW'(wt);
        flush_i       = fl;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        query_rs_i = '0;
        rst_i = 1'b1;
        model_reset();
        refresh_pool();
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_inflight", inflight_o, 0);
        chk("rst_push", pool_push_o, 0);
        chk("rst_ptag", pool_tag_o, 0);
        chk("rst_err", wb_err_o, 0);
        chk("rst_pop", pool_pop_o, 0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0);
        query_rs_i = '0;
        do_reset();

        // Three issues get tags 0,1,2; hazards follow the recorded rd values.
        for (int i = 0; i < 3; i++) begin
            drive(1, 5 + i, 0, 0, 0);
            #1 chk("t1_tag", issue_tag_o, i);
            chk("t1_pop", pool_pop_o, 1);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        query_rs_i[0] = 5'd6; query_rs_i[1] = 5'd0; query_rs_i[2] = 5'd9;
        #1 chk("t1_inflight", inflight_o, 3);
        chk("t1_haz6", hazard_o[0], 1);
        chk("t1_haz0", hazard_o[1], 0);
        tick();

        // WAW block, then writeback returns tag 0 one cycle later.
        do_reset();
        drive(1, 5, 0, 0, 0); tick();
        drive(1, 5, 0, 0, 0);
        #1 chk("t2_waw", issue_ready_o, 0);
        tick();
        drive(0, 0, 1, 0, 0); tick();
        drive(1, 5, 0, 0, 0);
        #1 chk("t2_push", pool_push_o, 1);
        chk("t2_ptag", pool_tag_o, 0);
        chk("t2_reissue", issue_ready_o, 1);
        tick();

        // Drain the pool, free tag 3, and see it reissued after the wrap.
        do_reset();
        for (int i = 0; i < NT; i++) begin drive(1, i + 1, 0, 0, 0); tick(); end
        drive(1, 20, 0, 0, 0);
        #1 chk("t3_empty", issue_ready_o, 0);
        tick();
        drive(0, 0, 1, 3, 0); tick();
        drive(0, 0, 0, 0, 0);
        #1 chk("t3_push", pool_push_o, 1);
        chk("t3_ptag", pool_tag_o, 3);
        tick();
        drive(1, 20, 0, 0, 0);
        #1 chk("t3_ready", issue_ready_o, 1);
        chk("t3_tag", issue_tag_o, 3);
        tick();

        // Plain flush with tags 0..3 in flight.
        do_reset();
        for (int i = 0; i < 4; i++) begin drive(1, i + 1, 0, 0, 0); tick(); end
        push_log.delete(); busy_cycles = 0;
        drive(0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0);
        repeat (9) tick();
        chk("t4_busy_cycles", busy_cycles, 8);
        chk("t4_npush", push_log.size(), 4);
        for (int i = 0; i < 4 && i < push_log.size(); i++) chk("t4_order", push_log[i], i);
        chk("t4_inflight", inflight_o, 0);
        chk("t4_idle", busy_o, 0);

        // Writeback of tag 2 while the scan sits at index 1 stalls the scan.
        do_reset();
        for (int i = 0; i < 4; i++) begin drive(1, i + 1, 0, 0, 0); tick(); end
        push_log.delete(); busy_cycles = 0;
        drive(0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0); tick();
        drive(0, 0, 1, 2, 0); tick();
        drive(0, 0, 0, 0, 0);
        repeat (9) tick();
        chk("t5_busy_cycles", busy_cycles, 9);
        chk("t5_npush", push_log.size(), 4);
        if (push_log.size() == 4) begin
            chk("t5_p0", push_log[0], 0);
            chk("t5_p1", push_log[1], 2);
            chk("t5_p2", push_log[2], 1);
            chk("t5_p3", push_log[3], 3);
        end

        // Writeback to an unallocated tag, then reset in the middle of a flush.
        do_reset();
        drive(1, 1, 0, 0, 0); tick();
        drive(0, 0, 1, 6, 0); tick();
        drive(0, 0, 0, 0, 0);
        #1 chk("t6_err", wb_err_o, 1);
        chk("t6_nopush", pool_push_o, 0);
        chk("t6_inflight", inflight_o, 1);
        tick();
        chk("t6_err_clr", wb_err_o, 0);
        drive(0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0); tick();
        chk("t6_busy", busy_o, 1);
        do_reset();
        tick();

        // Random traffic against the reference.
        do_reset();
        repeat (400) begin
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7), $urandom_range(0, 29) == 0);
            for (int q = 0; q < NQ; q++) query_rs_i[q] = RW'($urandom_range(0, 7));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/snitch_sb_tag_table.md
Name: snitch_sb_tag_table

Overview:
- Scoreboard tag table directly downstream of the scoreboard ID pool.
- Pops a free tag from the pool for every issued instruction and records the destination register against that tag.
- Reports RAW/WAW hazards to issue logic.
- On writeback or flush, returns tags to the pool through a single registered push port, so the pool's free list stays consistent.

Parameters:
- NumTags, 8, number of scoreboard tags; equals the pool depth.
- RegAddrWidth, 5, width of register addresses.
- NumQuery, 3, number of source-operand hazard query ports.
- TagWidth, $clog2(NumTags), derived tag width; never overridden.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- issue_valid_i  in  1  instruction wants a tag
- issue_rd_i  in  RegAddrWidth  destination register of the issuing instruction
- issue_ready_o  out  1  tag granted this cycle
- issue_tag_o  out  TagWidth  granted tag; valid while issue_valid_i && issue_ready_o
- pool_empty_i  in  1  pool has no free tag
- pool_tag_i  in  TagWidth  pool head tag
- pool_pop_o  out  1  pop pool head
- pool_push_o  out  1  return a tag to the pool
- pool_tag_o  out  TagWidth  tag being returned
- wb_valid_i  in  1  writeback completes
- wb_tag_i  in  TagWidth  tag of the completing instruction
- wb_err_o  out  1  registered one-cycle pulse: writeback hit an unallocated tag
- query_rs_i  in  NumQuery x RegAddrWidth  source registers to check
- hazard_o  out  NumQuery  source register has an in-flight producer
- flush_i  in  1  squash all in-flight entries
- busy_o  out  1  FSM is in FLUSH
- inflight_o  out  TagWidth+1  count of valid entries

Behaviour:
- State: per-tag valid bit and rd field; FSM {IDLE, FLUSH}; scan index (TagWidth bits); return register ret_valid_q / ret_tag_q; wb_err_q.
- Reset (async, rst_i high):
  - all valid bits 0; FSM IDLE; scan index 0; ret_valid_q 0; wb_err_q 0.
  - Outputs: pool_push_o 0, pool_tag_o 0, busy_o 0, inflight_o 0, wb_err_o 0.
  - issue_ready_o and pool_pop_o 0 until the pool reports non-empty.
  - Reset mid-flush abandons the scan; the pool is reset to full in the same event.
- Issue:
  - issue_ready_o = (FSM==IDLE) && !pool_empty_i && !flush_i && !waw, where waw = any valid entry with rd == issue_rd_i && issue_rd_i != 0.
  - Fire = issue_valid_i && issue_ready_o. On fire: pool_pop_o = 1 (combinational, same cycle) and issue_tag_o = pool_tag_i.
  - Next edge: valid[tag] <= 1, rd[tag] <= issue_rd_i.
  - rd == 0 still allocates a tag but never produces hazards.
- Hazard:
  - hazard_o[i] = query_rs_i[i] != 0 && any valid entry with rd == query_rs_i[i].
  - Computed from registered state only; an entry written back or issued this cycle affects hazard_o from the next cycle.
- Writeback:
  - wb_valid_i && valid[wb_tag_i]: next edge clears valid[wb_tag_i] and sets ret_valid_q = 1, ret_tag_q = wb_tag_i.
  - wb_valid_i to an unallocated tag: no state change; wb_err_o pulses high one cycle later.
  - Writebacks are accepted in both IDLE and FLUSH.
- Return port:
  - pool_push_o = ret_valid_q, pool_tag_o = ret_tag_q.
  - Latency is 1 cycle from writeback to push; the tag is re-poppable from the pool at the earliest 2 cycles after writeback.
  - The pool is never full on a push, because every returned tag was previously popped.
  - At most one return per cycle; writeback has priority over the flush scan.
- Flush:
  - flush_i in IDLE → FLUSH (next edge); scan index <= 0. flush_i in FLUSH is ignored.
  - Each FLUSH cycle with no valid writeback:
    - if valid[idx], clear valid[idx] and load the return register with idx;
    - then increment idx.
  - A cycle with a valid writeback stalls the scan (idx holds).
  - idx == NumTags-1 processed → IDLE.
  - Minimum flush duration is NumTags cycles.
  - busy_o = (FSM==FLUSH); issue_ready_o = 0 throughout.
  - Issue in the same cycle as flush_i is blocked.
- inflight_o:
  - registered count of valid bits, updated alongside valid;
  - +1 on fire, -1 on a valid writeback or a flush clear;
  - fire and clear in the same cycle leave the count unchanged.

Test Plan:
- Reset, pool full (tags 0..7 in order); issue rd=5,6,7 in three cycles → issue_tag_o=0,1,2, pool_pop_o high each cycle, inflight_o=3; query_rs_i[0]=6 → hazard_o[0]=1; query rd=0 → hazard_o=0.
- Issue rd=5 (tag 0); next cycle issue rd=5 again → issue_ready_o=0 (WAW). wb_tag_i=0 → following cycle pool_push_o=1, pool_tag_o=0; next issue rd=5 accepted.
- Issue 8 instructions → pool_empty_i=1, issue_ready_o=0; wb tag 3 → push tag 3 one cycle later; issue resumes with tag 3 once the pool wraps around.
- 4 tags in flight (0..3), assert flush_i → busy_o=1 for ≥8 cycles; pool_push_o pulses with tags 0,1,2,3 in ascending order; inflight_o=0; FSM back in IDLE.
- During the flush scan, wb_tag_i=2 arrives at idx 1 → push 2 first, scan stalls one cycle, tag 2 not pushed twice, 4 pushes total.
- wb_valid_i with tag 6 unallocated → wb_err_o=1 for exactly one cycle, no push, inflight_o unchanged. Assert rst_i mid-flush → all outputs return to reset values immediately.
